// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-mode constants
// and the baud-code decode used to size the sample-tick divisor.
package uart_pkg;
    localparam int DIV_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef struct packed {
        logic [2:0] baud;
        logic [1:0] parity;
        logic       stop2;
    } rx_cfg_t;

    function automatic int unsigned baud_rate(input logic [2:0] code);
        case (code)
            3'd1:    return 19200;
            3'd2:    return 38400;
            3'd3:    return 57600;
            3'd4:    return 115200;
            default: return 9600;
        endcase
    endfunction

    // Clock cycles per sample tick, minus one (counter terminal value).
    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input logic [2:0]  code,
                                             input int unsigned os);
        return clk_hz / (baud_rate(code) * os) - 1;
    endfunction
endpackage

// File: rtl/uart_frame_rx_if.sv
// Sample-tick generator link: the frame engine supplies enable and divisor,
// the tick generator returns a one-cycle strobe per oversample period.
interface uart_frame_rx_if;
    import uart_pkg::*;

    logic             en;
    logic [DIV_W-1:0] div;
    logic             tick;

    modport master (output en, output div, input tick);
    modport slave  (input en, input div, output tick);
endinterface

// File: rtl/uart_baud_tick.sv
// Divisor counter producing a tick every div+1 cycles while enabled;
// the count is held at zero whenever the enable is low.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    uart_frame_rx_if.slave bt
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!bt.en || cnt_q == bt.div) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bt.tick = bt.en && (cnt_q == bt.div);
endmodule

// File: rtl/uart_frame_rx.sv
// Oversampling UART frame receiver: 7-sample majority vote per bit,
// optional parity, one or two stop bits, configuration latched per frame.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [2:0]           Baud_set,
    input  logic [1:0]           Parity_mode,
    input  logic                 Stop_bits,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] Data,
    output logic                 Rx_Done,
    output logic                 Parity_err,
    output logic                 Frame_err,
    output logic                 Busy
);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int VLO = OVERSAMPLE / 2 - 3;
    localparam int VHI = OVERSAMPLE / 2 + 3;

    localparam logic [DIV_W-1:0] DIV0 = DIV_W'(tick_div(CLK_FREQ, 3'd0, OVERSAMPLE));
    localparam logic [DIV_W-1:0] DIV1 = DIV_W'(tick_div(CLK_FREQ, 3'd1, OVERSAMPLE));
    localparam logic [DIV_W-1:0] DIV2 = DIV_W'(tick_div(CLK_FREQ, 3'd2, OVERSAMPLE));
    localparam logic [DIV_W-1:0] DIV3 = DIV_W'(tick_div(CLK_FREQ, 3'd3, OVERSAMPLE));
    localparam logic [DIV_W-1:0] DIV4 = DIV_W'(tick_div(CLK_FREQ, 3'd4, OVERSAMPLE));

    rx_state_e            state_q, state_d;
    rx_cfg_t              cfg_q, cfg_d;
    logic [1:0]           sync_q;
    logic                 prev_q, armed_q;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [2:0]           ones_q, ones_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic                 scnt_q, scnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
    logic                 par_q, par_d, facc_q, facc_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 done_q, done_d, busy_q, busy_d;
    logic [DIV_W-1:0]     baud_div;
    logic                 rx_s, tick, fall, in_win, vote, vote_tick, bit_end;
    logic                 par_en, par_exp, last_stop;
    logic [2:0]           ones_s;

    uart_frame_rx_if baud_if ();
    assign baud_if.en  = (state_q != ST_IDLE);
    assign baud_if.div = baud_div;
    assign tick        = baud_if.tick;

    uart_baud_tick u_tick (.clk_i(Clk), .rst_i(Reset), .bt(baud_if.slave));

    always_comb begin
        case (cfg_q.baud)
            3'd1:    baud_div = DIV1;
            3'd2:    baud_div = DIV2;
            3'd3:    baud_div = DIV3;
            3'd4:    baud_div = DIV4;
            default: baud_div = DIV0;
        endcase
    end

    assign rx_s      = sync_q[1];
    assign fall      = armed_q && prev_q && !rx_s;
    assign in_win    = (tcnt_q >= TW'(VLO)) && (tcnt_q <= TW'(VHI));
    assign ones_s    = ones_q + {2'b00, rx_s};
    // The vote includes the sample taken on the deciding tick itself.
    assign vote      = (ones_s >= 3'd4);
    assign vote_tick = tick && (tcnt_q == TW'(VHI));
    assign bit_end   = tick && (tcnt_q == TW'(OVERSAMPLE - 1));
    assign par_en    = (cfg_q.parity == PAR_EVEN) || (cfg_q.parity == PAR_ODD);
    assign par_exp   = (^shreg_q) ^ (cfg_q.parity == PAR_ODD);
    assign last_stop = !cfg_q.stop2 || scnt_q;

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        tcnt_d  = tcnt_q;
        ones_d  = ones_q;
        bcnt_d  = bcnt_q;
        scnt_d  = scnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        facc_d  = facc_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        if (tick) begin
            tcnt_d = bit_end ? '0 : tcnt_q + 1'b1;
            ones_d = bit_end ? '0 : (in_win ? ones_s : ones_q);
        end
        case (state_q)
            ST_IDLE: if (fall) begin
                state_d      = ST_START;
                cfg_d.baud   = Baud_set;
                cfg_d.parity = Parity_mode;
                cfg_d.stop2  = Stop_bits;
                bcnt_d       = '0;
                scnt_d       = 1'b0;
                facc_d       = 1'b0;
            end
            ST_START: begin
                if (vote_tick && vote) state_d = ST_IDLE;
                else if (bit_end)      state_d = ST_DATA;
            end
            ST_DATA: begin
                if (vote_tick) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BW'(DATA_BITS - 1))
                        state_d = par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (vote_tick) par_d = vote;
                if (bit_end)   state_d = ST_STOP;
            end
            ST_STOP: begin
                // Finish mid final stop bit so an immediate next start edge is seen.
                if (vote_tick) begin
                    if (last_stop) begin
                        data_d  = shreg_q;
                        done_d  = 1'b1;
                        perr_d  = par_en && (par_q != par_exp);
                        ferr_d  = facc_q || !vote;
                        state_d = ST_IDLE;
                    end else begin
                        facc_d = facc_q || !vote;
                    end
                end
                if (bit_end) scnt_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) begin
            tcnt_d = '0;
            ones_d = '0;
        end
    end

    assign busy_d = (state_d != ST_IDLE) || done_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            tcnt_q  <= '0;
            ones_q  <= '0;
            bcnt_q  <= '0;
            scnt_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            facc_q  <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            prev_q  <= rx_s;
            armed_q <= 1'b1;
            state_q <= state_d;
            cfg_q   <= cfg_d;
            tcnt_q  <= tcnt_d;
            ones_q  <= ones_d;
            bcnt_q  <= bcnt_d;
            scnt_q  <= scnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            facc_q  <= facc_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Data       = data_q;
    assign Rx_Done    = done_q;
    assign Parity_err = perr_q;
    assign Frame_err  = ferr_q;
    assign Busy       = busy_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: serial frames are generated at the
// line level and results compared against expectations derived from the frame.
module tb_uart_frame_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 50000000;
    localparam int DBITS    = 8;
    localparam int OS       = 16;
    localparam int RATE4    = 115200;
    localparam int EXP_DIV  = CLK_FREQ / (RATE4 * OS) - 1;
    localparam int BITC     = (EXP_DIV + 1) * OS;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [2:0]       Baud_set = 3'd4;
    logic [1:0]       Parity_mode = 2'd0;
    logic             Stop_bits = 1'b0;
    logic             uart_rx = 1'b1;
    logic [DBITS-1:0] Data;
    logic             Rx_Done, Parity_err, Frame_err, Busy;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [DBITS-1:0] got_data[$];
    logic             got_perr[$], got_ferr[$], got_busy[$];

    always #5 Clk = ~Clk;

    uart_frame_rx #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(DBITS), .OVERSAMPLE(OS)) dut (
        .Clk(Clk), .Reset(Reset), .Baud_set(Baud_set), .Parity_mode(Parity_mode),
        .Stop_bits(Stop_bits), .uart_rx(uart_rx), .Data(Data), .Rx_Done(Rx_Done),
        .Parity_err(Parity_err), .Frame_err(Frame_err), .Busy(Busy)
    );

    uart_frame_rx_if bt_if ();
    uart_baud_tick u_bt (.clk_i(Clk), .rst_i(Reset), .bt(bt_if.slave));

    // Every high cycle of Rx_Done is recorded, so a stretched pulse shows up as extra results.
    always @(negedge Clk) begin
        if (Rx_Done === 1'b1) begin
            done_cnt++;
            got_data.push_back(Data);
            got_perr.push_back(Parity_err);
            got_ferr.push_back(Frame_err);
            got_busy.push_back(Busy);
        end
    end

    task automatic pop_result(output logic [DBITS-1:0] d, output logic pe,
                              output logic fe, output logic bz);
        if (got_data.size() == 0) begin
            d = 'x; pe = 1'bx; fe = 1'bx; bz = 1'bx;
        end else begin
            d  = got_data.pop_front();
            pe = got_perr.pop_front();
            fe = got_ferr.pop_front();
            bz = got_busy.pop_front();
        end
    endtask

    task automatic drive_bit(input logic b, input int cycles);
        uart_rx = b;
        repeat (cycles) @(negedge Clk);
    endtask

    // Line-level frame: start, LSB-first data, optional parity, stop bit(s).
    task automatic send_frame(input logic [DBITS-1:0] d, input logic [1:0] pm, input logic s2,
                              input logic flip, input logic [1:0] stop_low, input logic scramble);
        logic pb;
        Baud_set = 3'd4;
        Parity_mode = pm;
        Stop_bits = s2;
        drive_bit(1'b0, BITC);
        if (scramble) begin
            Baud_set = 3'($urandom_range(0, 7));
            Parity_mode = 2'($urandom_range(0, 3));
            Stop_bits = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < DBITS; i++) drive_bit(d[i], BITC);
        if (pm == 2'd1 || pm == 2'd2) begin
            pb = (^d) ^ (pm == 2'd2) ^ flip;
            drive_bit(pb, BITC);
        end
        drive_bit(!stop_low[0], BITC);
        if (s2) drive_bit(!stop_low[1], BITC);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        uart_rx = 1'b1;
        repeat (4) @(negedge Clk);
        checks++;
        if ({Data, Rx_Done, Parity_err, Frame_err, Busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {Data, Rx_Done, Parity_err, Frame_err, Busy});
        end
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_busy got=%b exp=0", Busy);
        end
    endtask

    task automatic test_baud_tick;
        int div, i, j, nt;
        div = $urandom_range(3, 40);
        bt_if.div = 16'(div);
        bt_if.en = 1'b0;
        nt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (bt_if.tick === 1'b1) nt++;
        end
        checks++;
        if (nt != 0) begin failures++; $display("FAIL tick_disabled got=%0d exp=0", nt); end
        bt_if.en = 1'b1;
        i = 0;
        while (bt_if.tick !== 1'b1 && i < 64) begin @(negedge Clk); i++; end
        j = 0;
        do begin @(negedge Clk); j++; end while (bt_if.tick !== 1'b1 && j < 64);
        checks++;
        if (j != div + 1) begin failures++; $display("FAIL tick_period got=%0d exp=%0d", j, div + 1); end
        bt_if.en = 1'b0;
    endtask

    task automatic test_basic;
        int n0;
        logic [DBITS-1:0] d;
        logic pe, fe, bz;
        n0 = done_cnt;
        send_frame(8'h55, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        repeat (BITC) @(negedge Clk);
        checks++;
        if (done_cnt - n0 != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - n0); end
        pop_result(d, pe, fe, bz);
        checks++;
        if (d !== 8'h55) begin failures++; $display("FAIL basic_data got=%h exp=55", d); end
        checks++;
        if ({pe, fe} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {pe, fe}); end
        checks++;
        if (bz !== 1'b1) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=1", bz); end
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL basic_busy_idle got=%b exp=0", Busy); end
        checks++;
        if (dut.baud_div !== 16'(EXP_DIV)) begin
            failures++; $display("FAIL basic_divisor got=%0d exp=%0d", dut.baud_div, EXP_DIV);
        end
    endtask

    task automatic test_parity;
        logic [DBITS-1:0] d;
        logic pe, fe, bz;
        int n0;
        // 0xA3 has four ones, so even parity expects a 0 parity bit.
        for (int f = 0; f < 2; f++) begin
            n0 = done_cnt;
            send_frame(8'hA3, 2'd1, 1'b0, (f == 0), 2'b00, 1'b0);
            repeat (BITC) @(negedge Clk);
            pop_result(d, pe, fe, bz);
            checks++;
            if (done_cnt - n0 != 1 || d !== 8'hA3) begin
                failures++; $display("FAIL parity_data_%0d got=%h/%0d exp=a3/1", f, d, done_cnt - n0);
            end
            checks++;
            if (pe !== (f == 0)) begin failures++; $display("FAIL parity_err_%0d got=%b exp=%b", f, pe, f == 0); end
        end
    endtask

    task automatic test_glitch;
        int n0;
        logic seen;
        n0 = done_cnt;
        seen = 1'b0;
        uart_rx = 1'b0;
        for (int k = 0; k < BITC; k++) begin
            if (k == 3 * (EXP_DIV + 1)) uart_rx = 1'b1;
            @(negedge Clk);
            if (Busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1 || Busy !== 1'b0) begin
            failures++; $display("FAIL glitch_busy got=seen%b/now%b exp=seen1/now0", seen, Busy);
        end
        repeat (BITC) @(negedge Clk);
        checks++;
        if (done_cnt != n0) begin failures++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - n0); end
    endtask

    task automatic test_stop_err;
        logic [DBITS-1:0] d, w;
        logic pe, fe, bz;
        int n0;
        w = 8'hC9;
        n0 = done_cnt;
        send_frame(w, 2'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        repeat (BITC) @(negedge Clk);
        pop_result(d, pe, fe, bz);
        checks++;
        if (done_cnt - n0 != 1 || d !== w) begin
            failures++; $display("FAIL stoperr_data got=%h/%0d exp=%h/1", d, done_cnt - n0, w);
        end
        checks++;
        if (fe !== 1'b1) begin failures++; $display("FAIL stoperr_frame_err got=%b exp=1", fe); end
    endtask

    task automatic test_back_to_back;
        logic [DBITS-1:0] d0, d1;
        logic pe, fe, bz;
        int n0;
        n0 = done_cnt;
        send_frame(8'h12, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        send_frame(8'h34, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        repeat (BITC) @(negedge Clk);
        checks++;
        if (done_cnt - n0 != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - n0); end
        pop_result(d0, pe, fe, bz);
        pop_result(d1, pe, fe, bz);
        checks++;
        if (d0 !== 8'h12 || d1 !== 8'h34) begin
            failures++; $display("FAIL b2b_data got=%h,%h exp=12,34", d0, d1);
        end
    endtask

    task automatic test_reset_midframe;
        logic [DBITS-1:0] w, d;
        logic pe, fe, bz;
        int n0;
        w = 8'hA5;
        drive_bit(1'b0, BITC);
        for (int i = 0; i < 4; i++) drive_bit(w[i], BITC);
        drive_bit(w[4], BITC / 2);
        Reset = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Data, Rx_Done, Parity_err, Frame_err, Busy} !== '0) begin
            failures++; $display("FAIL midreset_outputs got=%h exp=0", {Data, Rx_Done, Parity_err, Frame_err, Busy});
        end
        Reset = 1'b0;
        n0 = done_cnt;
        repeat (BITC) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || done_cnt != n0) begin
            failures++; $display("FAIL midreset_quiet got=busy%b/done%0d exp=busy0/done0", Busy, done_cnt - n0);
        end
        send_frame(8'h7E, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        repeat (BITC) @(negedge Clk);
        pop_result(d, pe, fe, bz);
        checks++;
        if (done_cnt - n0 != 1 || d !== 8'h7E || {pe, fe} !== 2'b00) begin
            failures++; $display("FAIL midreset_frame got=%h/%0d/%b exp=7e/1/00", d, done_cnt - n0, {pe, fe});
        end
    endtask

    // Random frames with the config ports scrambled mid-frame; the frame must
    // still decode with the settings present at its start edge.
    task automatic test_random;
        logic [DBITS-1:0] w, d;
        logic [1:0] pm, sl;
        logic s2, flip, pe, fe, bz, par_on, sent_pb, want_pb, exp_pe, exp_fe;
        int n0;
        for (int k = 0; k < 4; k++) begin
            w = DBITS'($urandom);
            pm = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            flip = 1'($urandom_range(0, 1));
            sl = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            par_on = (pm == 2'd1) || (pm == 2'd2);
            want_pb = (pm == 2'd2) ? ~(^w) : (^w);
            sent_pb = want_pb ^ flip;
            exp_pe = par_on && (sent_pb != want_pb);
            exp_fe = sl[0] || (s2 && sl[1]);
            n0 = done_cnt;
            send_frame(w, pm, s2, flip, sl, 1'b1);
            repeat (BITC) @(negedge Clk);
            pop_result(d, pe, fe, bz);
            checks++;
            if (done_cnt - n0 != 1 || d !== w) begin
                failures++; $display("FAIL rand%0d_data got=%h/%0d exp=%h/1", k, d, done_cnt - n0, w);
            end
            checks++;
            if (pe !== exp_pe || fe !== exp_fe) begin
                failures++; $display("FAIL rand%0d_flags got=pe%b fe%b exp=pe%b fe%b", k, pe, fe, exp_pe, exp_fe);
            end
            repeat (BITC) @(negedge Clk);
            checks++;
            if (Data !== w || Parity_err !== exp_pe || Frame_err !== exp_fe) begin
                failures++; $display("FAIL rand%0d_hold got=%h/%b/%b exp=%h/%b/%b", k, Data, Parity_err, Frame_err, w, exp_pe, exp_fe);
            end
        end
    endtask

    initial begin
        bt_if.en = 1'b0;
        bt_if.div = '0;
        test_reset();
        test_baud_tick();
        test_basic();
        test_parity();
        test_glitch();
        test_stop_err();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
